// File: rtl/ball_sprite_engine.sv
// Two-axis bouncing SIZE x SIZE sprite for the vga_adapter write port:
// each accepted frame tick erases the sprite, moves it once, then redraws it.
module ball_sprite_engine #(
   parameter int unsigned SCREEN_W = 160,
   parameter int unsigned SCREEN_H = 120,
   parameter int unsigned XW       = 8,
   parameter int unsigned YW       = 7,
   parameter int unsigned SIZE     = 4,
   parameter int unsigned X0       = 78,
   parameter int unsigned Y0       = 58,
   parameter logic [2:0]  BG       = 3'b000
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          frame_tick,
   input  logic          run,
   input  logic [2:0]    speed_x,
   input  logic [2:0]    speed_y,
   input  logic [2:0]    fg_colour,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic [2:0]    colour,
   output logic          plot,
   output logic          busy,
   output logic [XW-1:0] ball_x,
   output logic [YW-1:0] ball_y,
   output logic          bounce_x,
   output logic          bounce_y
);

   typedef enum logic [2:0] {S_INIT, S_IDLE, S_ERASE, S_MOVE, S_DRAW} state_t;

   localparam logic [3:0]  LAST_P = 4'(SIZE - 1);
   localparam logic [3:0]  ROWS   = 4'(SIZE);
   localparam logic [XW:0] XLIM   = (XW+1)'(SCREEN_W - SIZE);
   localparam logic [YW:0] YLIM   = (YW+1)'(SCREEN_H - SIZE);

   state_t        state_q, state_d;
   logic [3:0]    px_q, px_d, py_q, py_d;
   logic [XW-1:0] bx_q, bx_d, x_q, x_d;
   logic [YW-1:0] by_q, by_d, y_q, y_d;
   logic          dirx_q, dirx_d, diry_q, diry_d;
   logic [2:0]    colour_q, colour_d, emit_col;
   logic          plot_q, plot_d, busy_q, busy_d;
   logic          bncx_q, bncx_d, bncy_q, bncy_d;
   logic          emit, scan_done;
   logic [XW:0]   x_spd, x_sum;
   logic [YW:0]   y_spd, y_sum;

   // state_q names what the registered outputs currently show, so the first
   // erase/draw pixel is emitted on the same edge that enters that phase.
   always_comb begin
      state_d  = state_q;
      px_d     = px_q;
      py_d     = py_q;
      bx_d     = bx_q;
      by_d     = by_q;
      dirx_d   = dirx_q;
      diry_d   = diry_q;
      x_d      = x_q;
      y_d      = y_q;
      colour_d = colour_q;
      plot_d   = 1'b0;
      bncx_d   = 1'b0;
      bncy_d   = 1'b0;
      emit     = 1'b0;
      emit_col = colour_q;
      scan_done = (py_q == ROWS);
      x_spd    = (XW+1)'(speed_x);
      y_spd    = (YW+1)'(speed_y);
      x_sum    = {1'b0, bx_q} + x_spd;
      y_sum    = {1'b0, by_q} + y_spd;

      case (state_q)
         S_INIT: begin
            if (scan_done) begin
               state_d = S_IDLE;
               px_d    = '0;
               py_d    = '0;
            end else begin
               emit     = 1'b1;
               emit_col = (px_q == '0 && py_q == '0) ? fg_colour : colour_q;
            end
         end
         S_IDLE: begin
            if (frame_tick && run) begin
               state_d  = S_ERASE;
               emit     = 1'b1;
               emit_col = BG;
            end
         end
         S_ERASE: begin
            if (scan_done) begin
               state_d = S_MOVE;
               px_d    = '0;
               py_d    = '0;
               if (!dirx_q) begin
                  if (x_sum > XLIM) begin
                     bx_d   = XLIM[XW-1:0];
                     dirx_d = 1'b1;
                     bncx_d = 1'b1;
                  end else begin
                     bx_d = x_sum[XW-1:0];
                  end
               end else if ({1'b0, bx_q} < x_spd) begin
                  bx_d   = '0;
                  dirx_d = 1'b0;
                  bncx_d = 1'b1;
               end else begin
                  bx_d = bx_q - x_spd[XW-1:0];
               end
               if (!diry_q) begin
                  if (y_sum > YLIM) begin
                     by_d   = YLIM[YW-1:0];
                     diry_d = 1'b1;
                     bncy_d = 1'b1;
                  end else begin
                     by_d = y_sum[YW-1:0];
                  end
               end else if ({1'b0, by_q} < y_spd) begin
                  by_d   = '0;
                  diry_d = 1'b0;
                  bncy_d = 1'b1;
               end else begin
                  by_d = by_q - y_spd[YW-1:0];
               end
            end else begin
               emit     = 1'b1;
               emit_col = BG;
            end
         end
         S_MOVE: begin
            state_d  = S_DRAW;
            emit     = 1'b1;
            emit_col = fg_colour;
         end
         S_DRAW: begin
            if (scan_done) begin
               state_d = S_IDLE;
               px_d    = '0;
               py_d    = '0;
            end else begin
               emit = 1'b1;
            end
         end
         default: state_d = S_INIT;
      endcase

      if (emit) begin
         plot_d   = 1'b1;
         x_d      = bx_q + XW'(px_q);
         y_d      = by_q + YW'(py_q);
         colour_d = emit_col;
         if (px_q == LAST_P) begin
            px_d = '0;
            py_d = py_q + 4'd1;
         end else begin
            px_d = px_q + 4'd1;
         end
      end

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= S_INIT;
         px_q     <= '0;
         py_q     <= '0;
         bx_q     <= XW'(X0);
         by_q     <= YW'(Y0);
         dirx_q   <= 1'b0;
         diry_q   <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         colour_q <= BG;
         plot_q   <= 1'b0;
         busy_q   <= 1'b0;
         bncx_q   <= 1'b0;
         bncy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         px_q     <= px_d;
         py_q     <= py_d;
         bx_q     <= bx_d;
         by_q     <= by_d;
         dirx_q   <= dirx_d;
         diry_q   <= diry_d;
         x_q      <= x_d;
         y_q      <= y_d;
         colour_q <= colour_d;
         plot_q   <= plot_d;
         busy_q   <= busy_d;
         bncx_q   <= bncx_d;
         bncy_q   <= bncy_d;
      end
   end

   assign x        = x_q;
   assign y        = y_q;
   assign colour   = colour_q;
   assign plot     = plot_q;
   assign busy     = busy_q;
   assign ball_x   = bx_q;
   assign ball_y   = by_q;
   assign bounce_x = bncx_q;
   assign bounce_y = bncy_q;

endmodule

// File: tb/tb_ball_sprite_engine.sv
// Bench for ball_sprite_engine: every frame's full pixel trace is predicted
// from a plain-integer position/direction model of the bouncing sprite.
module tb_ball_sprite_engine;
   localparam int XW = 8, YW = 7, SW = 160, SH = 120, S = 4, N = S * S, X0 = 78, Y0 = 58;
   localparam logic [2:0] BGC = 3'b000;

   logic          clk = 1'b0, resetn = 1'b0, frame_tick = 1'b0, run = 1'b0;
   logic [2:0]    speed_x = '0, speed_y = '0, fg_colour = '0;
   logic [XW-1:0] x, ball_x;
   logic [YW-1:0] y, ball_y;
   logic [2:0]    colour;
   logic          plot, busy, bounce_x, bounce_y;

   int total = 0, bad = 0;
   int m_x, m_y, m_dx, m_dy;

   always #5 clk = ~clk;

   ball_sprite_engine dut (
      .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .run(run),
      .speed_x(speed_x), .speed_y(speed_y), .fg_colour(fg_colour),
      .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy),
      .ball_x(ball_x), .ball_y(ball_y), .bounce_x(bounce_x), .bounce_y(bounce_y)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One axis of the sprite: travel, clamp at the wall, reverse on a hit.
   function automatic void mv(inout int p, inout int d, input int s, input int lim, output bit b);
      int np;
      b  = 1'b0;
      np = p + d * s;
      if (np > lim) begin
         p = lim; d = -1; b = 1'b1;
      end else if (np < 0) begin
         p = 0; d = 1; b = 1'b1;
      end else begin
         p = np;
      end
   endfunction

   task automatic run_frame(input int sx, input int sy, input logic [2:0] fgd, input bit inject,
                            output int seq_err, output int busy_len, output int nbx, output int nby);
      int ox, oy, ex, ey, ec;
      bit bxf, byf, ep, eb, ebx, eby;
      ox = m_x; oy = m_y;
      mv(m_x, m_dx, sx, SW - S, bxf);
      mv(m_y, m_dy, sy, SH - S, byf);
      seq_err = 0; busy_len = 0; nbx = 0; nby = 0;
      speed_x = 3'(sx); speed_y = 3'(sy); run = 1'b1; fg_colour = ~fgd; frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      for (int c = 0; c <= 2 * N + 1; c++) begin
         if (c > 0) step();
         ep = 0; eb = 1; ebx = 0; eby = 0; ex = 0; ey = 0; ec = 0;
         if (c < N) begin
            ep = 1; ex = ox + c % S; ey = oy + c / S; ec = int'(BGC);
         end else if (c == N) begin
            ebx = bxf; eby = byf;
         end else if (c <= 2 * N) begin
            ep = 1; ex = m_x + (c - N - 1) % S; ey = m_y + (c - N - 1) / S; ec = int'(fgd);
         end else begin
            eb = 0;
         end
         if (busy) busy_len++;
         if (bounce_x) nbx++;
         if (bounce_y) nby++;
         if (plot !== ep || busy !== eb || bounce_x !== ebx || bounce_y !== eby ||
             (ep && (x !== XW'(ex) || y !== YW'(ey) || colour !== 3'(ec)))) begin
            if (seq_err == 0)
               $display("  note: frame cycle %0d got plot=%b busy=%b x=%0d y=%0d col=%0d bx=%b by=%b want plot=%b busy=%b x=%0d y=%0d col=%0d bx=%b by=%b",
                        c, plot, busy, x, y, colour, bounce_x, bounce_y, ep, eb, ex, ey, ec, ebx, eby);
            seq_err++;
         end
         if (inject && c == 4) frame_tick = 1'b1;
         if (c == 5) begin frame_tick = 1'b0; fg_colour = fgd; end
         if (c == N + 4) fg_colour = ~fgd;
      end
      for (int w = 0; w < 200 && busy; w++) begin
         step();
         if (busy) busy_len++;
      end
   endtask

   task automatic collect_init(input logic [2:0] fgd, output int seq_err, output int busy_len);
      int ex, ey;
      bit ep, eb;
      m_x = X0; m_y = Y0; m_dx = 1; m_dy = 1;
      seq_err = 0; busy_len = 0;
      fg_colour = fgd; frame_tick = 1'b0; resetn = 1'b1;
      for (int c = 0; c <= N; c++) begin
         step();
         ep = (c < N); eb = (c < N);
         ex = X0 + c % S; ey = Y0 + c / S;
         if (busy) busy_len++;
         if (plot !== ep || busy !== eb || bounce_x !== 1'b0 || bounce_y !== 1'b0 ||
             (ep && (x !== XW'(ex) || y !== YW'(ey) || colour !== fgd))) begin
            if (seq_err == 0)
               $display("  note: init cycle %0d got plot=%b busy=%b x=%0d y=%0d col=%0d want plot=%b busy=%b x=%0d y=%0d col=%0d",
                        c, plot, busy, x, y, colour, ep, eb, ex, ey, fgd);
            seq_err++;
         end
         if (c == 2) fg_colour = ~fgd;
      end
      for (int w = 0; w < 200 && busy; w++) begin
         step();
         if (busy) busy_len++;
      end
   endtask

   task automatic test_reset();
      int se, bl;
      resetn = 1'b0; run = 1'b0; frame_tick = 1'b0;
      repeat (3) step();
      total++; if (plot !== 1'b0) begin bad++; $display("FAIL rst_plot: got %b want 0", plot); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      total++; if (x !== '0 || y !== '0) begin bad++; $display("FAIL rst_xy: got %0d,%0d want 0,0", x, y); end
      total++; if (colour !== BGC) begin bad++; $display("FAIL rst_colour: got %0d want %0d", colour, BGC); end
      total++; if (ball_x !== XW'(X0) || ball_y !== YW'(Y0)) begin bad++; $display("FAIL rst_ball: got %0d,%0d want %0d,%0d", ball_x, ball_y, X0, Y0); end
      total++; if (bounce_x !== 1'b0 || bounce_y !== 1'b0) begin bad++; $display("FAIL rst_bounce: got %b%b want 00", bounce_x, bounce_y); end
      collect_init(3'b111, se, bl);
      total++; if (se !== 0) begin bad++; $display("FAIL init_trace: got %0d bad cycles want 0", se); end
      total++; if (bl !== N) begin bad++; $display("FAIL init_busy_len: got %0d want %0d", bl, N); end
      total++; if (ball_x !== 8'd78 || ball_y !== 7'd58) begin bad++; $display("FAIL init_ball: got %0d,%0d want 78,58", ball_x, ball_y); end
   endtask

   task automatic test_basic_move();
      int se, bl, nbx, nby;
      run_frame(1, 1, 3'b011, 1'b0, se, bl, nbx, nby);
      total++; if (se !== 0) begin bad++; $display("FAIL basic_trace: got %0d bad cycles want 0", se); end
      total++; if (bl !== 2 * N + 1) begin bad++; $display("FAIL basic_busy_len: got %0d want %0d", bl, 2 * N + 1); end
      total++; if (nbx !== 0 || nby !== 0) begin bad++; $display("FAIL basic_bounce: got %0d,%0d want 0,0", nbx, nby); end
      total++; if (ball_x !== 8'd79 || ball_y !== 7'd59) begin bad++; $display("FAIL basic_ball: got %0d,%0d want 79,59", ball_x, ball_y); end
   endtask

   task automatic test_ignored_ticks();
      int se, bl, nbx, nby, plots, busies;
      run_frame(2, 1, 3'b100, 1'b1, se, bl, nbx, nby);
      total++; if (se !== 0) begin bad++; $display("FAIL busy_tick_trace: got %0d bad cycles want 0", se); end
      total++; if (bl !== 2 * N + 1) begin bad++; $display("FAIL busy_tick_len: got %0d want %0d", bl, 2 * N + 1); end
      plots = 0; busies = 0;
      run = 1'b0; frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (plot) plots++;
         if (busy) busies++;
         step();
      end
      run = 1'b1;
      total++; if (plots !== 0 || busies !== 0) begin bad++; $display("FAIL run0_tick: got plots=%0d busy=%0d want 0,0", plots, busies); end
      total++; if (ball_x !== XW'(m_x) || ball_y !== YW'(m_y)) begin bad++; $display("FAIL run0_ball: got %0d,%0d want %0d,%0d", ball_x, ball_y, m_x, m_y); end
   endtask

   task automatic test_wall_x();
      int se, bl, nbx, nby, errs;
      resetn = 1'b0; step();
      collect_init(3'b001, se, bl);
      errs = se;
      for (int i = 0; i < 11; i++) begin run_frame(7, 0, 3'b010, 1'b0, se, bl, nbx, nby); errs += se; end
      total++; if (ball_x !== 8'd155) begin bad++; $display("FAIL wallr_pre: got %0d want 155", ball_x); end
      run_frame(2, 0, 3'b010, 1'b0, se, bl, nbx, nby); errs += se;
      total++; if (ball_x !== 8'd156 || nbx !== 1) begin bad++; $display("FAIL wallr_hit: got x=%0d pulses=%0d want 156,1", ball_x, nbx); end
      run_frame(2, 0, 3'b010, 1'b0, se, bl, nbx, nby); errs += se;
      total++; if (ball_x !== 8'd154 || nbx !== 0) begin bad++; $display("FAIL wallr_back: got x=%0d pulses=%0d want 154,0", ball_x, nbx); end
      for (int i = 0; i < 21; i++) begin run_frame(7, 0, 3'b110, 1'b0, se, bl, nbx, nby); errs += se; end
      run_frame(6, 0, 3'b110, 1'b0, se, bl, nbx, nby); errs += se;
      total++; if (ball_x !== 8'd1) begin bad++; $display("FAIL walll_pre: got %0d want 1", ball_x); end
      run_frame(2, 0, 3'b110, 1'b0, se, bl, nbx, nby); errs += se;
      total++; if (ball_x !== 8'd0 || nbx !== 1) begin bad++; $display("FAIL walll_hit: got x=%0d pulses=%0d want 0,1", ball_x, nbx); end
      run_frame(2, 0, 3'b110, 1'b0, se, bl, nbx, nby); errs += se;
      total++; if (ball_x !== 8'd2 || ball_y !== 7'd58) begin bad++; $display("FAIL walll_back: got %0d,%0d want 2,58", ball_x, ball_y); end
      total++; if (errs !== 0) begin bad++; $display("FAIL wall_traces: got %0d bad cycles want 0", errs); end
   endtask

   task automatic test_corner();
      int se, bl, nbx, nby, errs;
      resetn = 1'b0; step();
      collect_init(3'b101, se, bl);
      errs = se;
      for (int i = 0; i < 8; i++) begin run_frame(7, 7, 3'b011, 1'b0, se, bl, nbx, nby); errs += se; end
      for (int i = 0; i < 3; i++) begin run_frame(7, 0, 3'b011, 1'b0, se, bl, nbx, nby); errs += se; end
      run_frame(1, 2, 3'b011, 1'b0, se, bl, nbx, nby); errs += se;
      total++; if (ball_x !== 8'd156 || ball_y !== 7'd116 || nbx !== 0 || nby !== 0) begin bad++;
         $display("FAIL corner_exact: got %0d,%0d pulses %0d,%0d want 156,116 pulses 0,0", ball_x, ball_y, nbx, nby); end
      run_frame(3, 3, 3'b011, 1'b0, se, bl, nbx, nby); errs += se;
      total++; if (ball_x !== 8'd156 || ball_y !== 7'd116 || nbx !== 1 || nby !== 1) begin bad++;
         $display("FAIL corner_hit: got %0d,%0d pulses %0d,%0d want 156,116 pulses 1,1", ball_x, ball_y, nbx, nby); end
      run_frame(3, 3, 3'b011, 1'b0, se, bl, nbx, nby); errs += se;
      total++; if (ball_x !== 8'd153 || ball_y !== 7'd113) begin bad++; $display("FAIL corner_back: got %0d,%0d want 153,113", ball_x, ball_y); end
      total++; if (errs !== 0) begin bad++; $display("FAIL corner_traces: got %0d bad cycles want 0", errs); end
   endtask

   task automatic test_reset_mid_draw();
      int se, bl, nbx, nby;
      speed_x = 3'd1; speed_y = 3'd1; fg_colour = 3'b010; run = 1'b1; frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      for (int c = 1; c <= N + 8; c++) step();
      total++; if (plot !== 1'b1) begin bad++; $display("FAIL mid_draw_active: got plot=%b want 1", plot); end
      resetn = 1'b0;
      step();
      total++; if (plot !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_rst_out: got plot=%b busy=%b want 0,0", plot, busy); end
      total++; if (ball_x !== 8'd78 || ball_y !== 7'd58) begin bad++; $display("FAIL mid_rst_ball: got %0d,%0d want 78,58", ball_x, ball_y); end
      step();
      collect_init(3'b101, se, bl);
      total++; if (se !== 0 || bl !== N) begin bad++; $display("FAIL mid_rst_init: got %0d bad cycles busy %0d want 0,%0d", se, bl, N); end
      run_frame(1, 1, 3'b110, 1'b0, se, bl, nbx, nby);
      total++; if (se !== 0 || ball_x !== 8'd79 || ball_y !== 7'd59) begin bad++;
         $display("FAIL mid_rst_dir: got %0d bad cycles ball %0d,%0d want 0 and 79,59", se, ball_x, ball_y); end
   endtask

   task automatic test_random();
      int se, bl, nbx, nby, sx, sy;
      logic [2:0] fg;
      for (int i = 0; i < 30; i++) begin
         sx = $urandom_range(0, 7);
         sy = $urandom_range(0, 7);
         fg = 3'($urandom_range(0, 7));
         run_frame(sx, sy, fg, ($urandom_range(0, 3) == 0), se, bl, nbx, nby);
         total++; if (se !== 0) begin bad++; $display("FAIL rand_trace[%0d]: got %0d bad cycles want 0", i, se); end
         total++; if (ball_x !== XW'(m_x) || ball_y !== YW'(m_y)) begin bad++;
            $display("FAIL rand_ball[%0d]: got %0d,%0d want %0d,%0d", i, ball_x, ball_y, m_x, m_y); end
         repeat ($urandom_range(0, 3)) step();
      end
   endtask

   initial begin
      test_reset();
      test_basic_move();
      test_ignored_ticks();
      test_wall_x();
      test_corner();
      test_reset_mid_draw();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
